// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the core's instruction-fetch and data ports onto the
// single RAM request port.
//
// A grant latches the winning request (address, write data, op, owner). The
// RAM strobes come only from that latch. The arbiter then waits for ramready
// or for the timeout, and returns registered load data to the owner.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; arbitrate and latch the winner
// BUSY  | latched request driven to RAM; wait for ramready/timeout
// DONE  | owner's wait low for this one cycle; no new grant
//
// Ports:
//   CLK, rst               clock, synchronous active-high reset
//   iREN, iaddr            instruction fetch request
//   iload, iwait           fetch data (registered), fetch stall
//   dREN, dWEN             data read/write request (dWEN wins)
//   daddr, dstore          data address and write data
//   dload, dwait           read data (registered), data stall
//   ramREN, ramWEN         RAM request strobes
//   ramaddr, ramstore      RAM address and write data
//   ramload, ramready      RAM read data and completion
//   err                    sticky timeout flag
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              err
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              we_q, we_d;
  logic              own_d_q, own_d_d;   // 1 = data port owns the access
  logic [SW-1:0]     dstreak_q, dstreak_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              err_q, err_d;

  logic d_req;
  logic streak_hit;
  logic busy;

  assign d_req      = dREN | dWEN;
  // An instruction has waited through MAX_DSTREAK data grants: it goes next.
  assign streak_hit = iREN && (dstreak_q == SW'(MAX_DSTREAK));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    we_d      = we_q;
    own_d_d   = own_d_q;
    dstreak_d = dstreak_q;
    tcnt_d    = tcnt_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (d_req && !streak_hit) begin
          addr_d    = daddr;
          store_d   = dstore;
          we_d      = dWEN;
          own_d_d   = 1'b1;
          dstreak_d = iREN ? dstreak_q + SW'(1) : '0;
          // tcnt holds the number of BUSY cycles including the current one.
          tcnt_d    = 8'd1;
          state_d   = S_BUSY;
        end else if (iREN) begin
          addr_d    = iaddr;
          store_d   = '0;
          we_d      = 1'b0;
          own_d_d   = 1'b0;
          dstreak_d = '0;
          tcnt_d    = 8'd1;
          state_d   = S_BUSY;
        end
      end

      S_BUSY: begin
        if (ramready) begin
          if (!we_q) begin
            if (own_d_q) dload_d = ramload;
            else         iload_d = ramload;
          end
          tcnt_d  = '0;
          state_d = S_DONE;
        end else if (tcnt_q == 8'(TIMEOUT)) begin
          err_d = 1'b1;
          if (own_d_q) dload_d = '0;
          else         iload_d = '0;
          tcnt_d  = '0;
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      we_q      <= 1'b0;
      own_d_q   <= 1'b0;
      dstreak_q <= '0;
      tcnt_q    <= '0;
      iload_q   <= '0;
      dload_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      we_q      <= we_d;
      own_d_q   <= own_d_d;
      dstreak_q <= dstreak_d;
      tcnt_q    <= tcnt_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      err_q     <= err_d;
    end
  end

  // Gating with rst keeps the strobes quiet in the reset cycle itself, even
  // if the reset lands while an access is in flight.
  assign busy     = (state_q == S_BUSY) && !rst;
  assign ramREN   = busy && !we_q;
  assign ramWEN   = busy && we_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  assign iwait = iREN && !((state_q == S_DONE) && !own_d_q);
  assign dwait = d_req && !((state_q == S_DONE) && own_d_q);

  assign iload = iload_q;
  assign dload = dload_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAX_DS = 4;

  logic        CLK;
  logic        rst;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAX_DS), .TIMEOUT(255)
  ) dut (
    .CLK(CLK), .rst(rst),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Fixed initial RAM contents.
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h0001_0001) ^ 32'h5A5A_C3C3;
  endfunction

  // RAM responder: ready after ram_lat strobed cycles (0 = never).
  logic [31:0] mem [logic [31:0]];
  int          ram_lat    = 1;
  int          ram_cnt    = 0;
  bit          ram_manual = 1'b0;

  initial begin
    ramready = 1'b0;
    ramload  = 32'h0;
  end

  always @(posedge CLK) begin
    #1;
    if (!ram_manual) begin
      if (ramREN === 1'b1 || ramWEN === 1'b1) begin
        ram_cnt = ram_cnt + 1;
        if (ram_lat != 0 && ram_cnt == ram_lat) begin
          ramready = 1'b1;
          if (ramWEN === 1'b1) mem[ramaddr] = ramstore;
          else ramload = mem.exists(ramaddr) ? mem[ramaddr] : ram_init(ramaddr);
        end else begin
          ramready = 1'b0;
          ramload  = $urandom;
        end
      end else begin
        ram_cnt  = 0;
        ramready = 1'b0;
        ramload  = $urandom;
      end
    end
  end

  // Reference memory for the random phase, updated when a write completes.
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ram_init(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int k;
    int ng;
    int streak;
    bit exp_i;
    // random-phase model state
    bit          i_pend, d_pend, d_we, d_both;
    logic [31:0] i_a, d_a, d_data;
    int          i_done, d_done, free_at, win_lo, win_hi, lat;
    bit          win_we;
    logic [31:0] win_addr, win_data, exp_iload, exp_dload;

    rst = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;

    // ---- reset defaults and first fetch
    cyc(); cyc();
    #1;
    check("rst_iload",  iload, 0);
    check("rst_dload",  dload, 0);
    check("rst_iwait",  32'(iwait), 0);
    check("rst_dwait",  32'(dwait), 0);
    check("rst_strobe", {30'd0, ramREN, ramWEN}, 0);
    check("rst_addr",   ramaddr, 0);
    check("rst_store",  ramstore, 0);
    check("rst_err",    32'(err), 0);
    rst = 1'b0; iREN = 1'b1; iaddr = 32'h40; ram_lat = 1;
    cyc(); #1;
    check("f1_busy_ren",  32'(ramREN), 1);
    check("f1_busy_addr", ramaddr, 32'h40);
    check("f1_busy_iwait", 32'(iwait), 1);
    cyc(); #1;
    check("f1_done_iwait", 32'(iwait), 0);
    check("f1_done_iload", iload, 32'hDEADBEEF);
    iREN = 1'b0;

    // ---- simultaneous data read and fetch, RAM latency 3
    cyc();
    dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h04; ram_lat = 3;
    for (int j = 1; j <= 9; j++) begin
      cyc(); #1;
      if (j <= 3) begin
        check("sim_d_addr", ramaddr, 32'h100);
        check("sim_d_ren",  32'(ramREN), 1);
        check("sim_d_dwait", 32'(dwait), 1);
      end
      if (j == 4) begin
        check("sim_d_done_dwait", 32'(dwait), 0);
        check("sim_d_dload", dload, ram_init(32'h100));
        check("sim_d_done_iwait", 32'(iwait), 1);
        dREN = 1'b0;
      end
      if (j == 5) check("sim_idle_ren", 32'(ramREN), 0);
      if (j >= 6 && j <= 8) begin
        check("sim_i_addr", ramaddr, 32'h04);
        check("sim_i_iwait", 32'(iwait), 1);
      end
      if (j == 9) begin
        check("sim_i_done_iwait", 32'(iwait), 0);
        check("sim_i_iload", iload, ram_init(32'h04));
        iREN = 1'b0;
      end
    end

    // ---- write, operands changed mid-access must not leak through
    cyc();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678; ram_lat = 2;
    for (int j = 1; j <= 3; j++) begin
      cyc(); #1;
      if (j <= 2) begin
        check("wr_wen",   32'(ramWEN), 1);
        check("wr_ren",   32'(ramREN), 0);
        check("wr_addr",  ramaddr, 32'h200);
        check("wr_store", ramstore, 32'h12345678);
        daddr = 32'h999; dstore = 32'h0;
      end else begin
        check("wr_done_dwait", 32'(dwait), 0);
        check("wr_dload_held", dload, ram_init(32'h100));
        check("wr_done_wen", 32'(ramWEN), 0);
        dWEN = 1'b0;
      end
    end

    // ---- starvation guard
    cyc();
    dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h500; ram_lat = 1;
    ng = 0; streak = 0; k = 0;
    while (k < 40 && ng < 10) begin
      cyc(); #1; k++;
      if (ramREN === 1'b1) begin
        exp_i = (streak == MAX_DS);
        streak = exp_i ? 0 : streak + 1;
        check("grant_order", ramaddr, exp_i ? 32'h500 : 32'h300);
        ng++;
      end
    end
    check("grant_count", 32'(ng), 10);
    dREN = 1'b0; iREN = 1'b0;
    cyc(); cyc();

    // ---- ready exactly on the last allowed BUSY cycle is a success
    cyc();
    dREN = 1'b1; daddr = 32'h88; ram_lat = 255; k = 0;
    do begin cyc(); k++; #1; end while (dwait !== 1'b0 && k < 400);
    check("edge_latency", 32'(k), 256);
    check("edge_err",     32'(err), 0);
    check("edge_dload",   dload, ram_init(32'h88));
    dREN = 1'b0;

    // ---- timeout
    cyc();
    dREN = 1'b1; daddr = 32'h8C; ram_lat = 0; k = 0;
    do begin cyc(); k++; #1; end while (dwait !== 1'b0 && k < 400);
    check("to_latency", 32'(k), 256);
    check("to_err",     32'(err), 1);
    check("to_dload",   dload, 0);
    check("to_done_ren", 32'(ramREN), 0);
    dREN = 1'b0;
    cyc();
    iREN = 1'b1; iaddr = 32'h44; ram_lat = 1;
    cyc(); cyc(); #1;
    check("to_next_iwait", 32'(iwait), 0);
    check("to_next_iload", iload, ram_init(32'h44));
    check("to_err_sticky", 32'(err), 1);
    iREN = 1'b0;

    // ---- reset in the middle of a read
    cyc();
    dREN = 1'b1; daddr = 32'h48; ram_lat = 0;
    cyc(); #1;
    check("rb_busy_ren", 32'(ramREN), 1);
    cyc();
    rst = 1'b1;
    #1;
    check("rb_rst_cycle_ren", 32'(ramREN), 0);
    cyc();
    rst = 1'b0; dREN = 1'b0;
    ram_manual = 1'b1; ramready = 1'b1; ramload = 32'hBAD0BAD0;
    #1;
    check("rb_after_ren",   {30'd0, ramREN, ramWEN}, 0);
    check("rb_after_err",   32'(err), 0);
    check("rb_after_dload", dload, 0);
    check("rb_after_iload", iload, 0);
    cyc(); #1;
    check("rb_late_dload", dload, 0);
    check("rb_late_iload", iload, 0);
    check("rb_late_ren",   32'(ramREN), 0);
    ramready = 1'b0; ram_manual = 1'b0;

    // ---- random phase against the transaction-level model
    ref_mem[32'h200] = 32'h12345678;
    i_pend = 0; d_pend = 0; d_we = 0; d_both = 0;
    i_a = 32'h1000; d_a = 32'h1000; d_data = 0;
    i_done = -10; d_done = -10; free_at = 0; win_lo = 1; win_hi = 0;
    win_we = 0; win_addr = 0; win_data = 0;
    exp_iload = 0; exp_dload = 0; streak = 0;
    cyc();
    for (int c = 0; c < 400; c++) begin
      if (i_pend && c == i_done + 1) i_pend = 0;
      if (d_pend && c == d_done + 1) d_pend = 0;
      if (!i_pend && $urandom_range(0, 2) != 0) begin
        i_pend = 1;
        i_a = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1;
        d_we   = 1'($urandom_range(0, 1));
        d_both = 1'($urandom_range(0, 1));
        d_a    = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        d_data = $urandom;
      end
      iREN   = i_pend;
      iaddr  = i_a;
      dREN   = d_pend && (!d_we || d_both);
      dWEN   = d_pend && d_we;
      daddr  = d_a;
      dstore = d_data;

      if (c >= free_at && (i_pend || d_pend)) begin
        lat = $urandom_range(1, 4);
        ram_lat = lat;
        if (d_pend && !(i_pend && streak == MAX_DS)) begin
          streak = i_pend ? streak + 1 : 0;
          win_we = d_we; win_addr = d_a; win_data = d_data;
          d_done = c + lat + 1;
        end else begin
          streak = 0;
          win_we = 0; win_addr = i_a; win_data = 0;
          i_done = c + lat + 1;
        end
        win_lo  = c + 1;
        win_hi  = c + lat;
        free_at = c + lat + 2;
      end

      #1;
      check("rnd_iwait", 32'(iwait), 32'(i_pend && c != i_done));
      check("rnd_dwait", 32'(dwait), 32'(d_pend && c != d_done));
      if (c >= win_lo && c <= win_hi) begin
        check("rnd_strobe", {30'd0, ramREN, ramWEN}, win_we ? 32'd1 : 32'd2);
        check("rnd_addr", ramaddr, win_addr);
        if (win_we) check("rnd_store", ramstore, win_data);
      end else begin
        check("rnd_quiet", {30'd0, ramREN, ramWEN}, 0);
      end
      if (c == i_done) exp_iload = ref_read(i_a);
      if (c == d_done) begin
        if (d_we) ref_mem[d_a] = d_data;
        else exp_dload = ref_read(d_a);
      end
      check("rnd_iload", iload, exp_iload);
      check("rnd_dload", dload, exp_dload);
      check("rnd_err",   32'(err), 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the scheduler core and the `ram` block. It merges the core's instruction-fetch port and data port onto the one RAM request port. It latches each granted request, holds it stable until the RAM signals completion, and returns registered load data to the winning requester. Data accesses have priority; a streak limit guarantees instruction fetch is never starved, and a timeout stops a stuck RAM from hanging the core.

## Interface
- Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_DSTREAK`, 4, consecutive data grants allowed while an instruction request waits
- `TIMEOUT`, 255, BUSY cycles before abort (8-bit counter)
- Ports:
- `CLK`  in  1  clock. One clock domain; everything here is on `CLK`.
- `rst`  in  1  reset, synchronous, active-high
- `iREN`  in  1  instruction fetch request
- `iaddr`  in  ADDR_W  fetch address
- `iload`  out  DATA_W  fetch data, registered
- `iwait`  out  1  fetch stall
- `dREN`, `dWEN`  in  1 each  data read / write request (mutually exclusive; `dWEN` wins if both are high)
- `daddr`  in  ADDR_W  data address
- `dstore`  in  DATA_W  write data
- `dload`  out  DATA_W  read data, registered
- `dwait`  out  1  data stall
- `ramREN`, `ramWEN`  out  1 each  RAM request strobes
- `ramaddr`  out  ADDR_W  RAM address
- `ramstore`  out  DATA_W  RAM write data
- `ramload`  in  DATA_W  RAM read data, valid when `ramready`
- `ramready`  in  1  RAM access complete this cycle
- `err`  out  1  sticky timeout flag

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - If `dREN|dWEN` is asserted and the streak limit is not hit, grant data.
  - Otherwise, if `iREN` is asserted, grant instruction.
  - On a grant: latch addr, store data, op type and owner into the request register; go to BUSY.
- **Streak rule:**
  - `dstreak` counts consecutive data grants made while `iREN` was high.
  - When `dstreak == MAX_DSTREAK` and `iREN` is high, the next grant goes to instruction even if data is pending.
  - `dstreak` clears on any instruction grant, and whenever a data grant occurs with `iREN` low.
- **BUSY:**
  - `ramREN`/`ramWEN`/`ramaddr`/`ramstore` are driven from the latch only, never from the live inputs.
  - `tcnt` increments each BUSY cycle.
  - On `ramready`: capture `ramload` into the owner's load register (reads only; writes leave it unchanged); go to DONE.
  - If `tcnt == TIMEOUT` without `ramready`: set `err`, load register ← 0, go to DONE.
- **DONE:**
  - The owner's wait is low for exactly this cycle.
  - No grant is made in DONE, even though the owner's request is still high. This prevents re-granting the same request.
  - Next state is IDLE.
- **Outside the RAM window:** all RAM strobes are 0 in IDLE and DONE.
- **Wait outputs:**
  - `iwait = iREN & !(DONE & owner==I)`.
  - `dwait = (dREN|dWEN) & !(DONE & owner==D)`.
  - A requester with no request sees wait = 0.
- **Requester contract:** hold the request and its operands stable while wait = 1. Changing them mid-BUSY has no effect on the access in flight.
- **Reset:**
  - FSM → IDLE; `dstreak`, `tcnt` → 0; `iload`, `dload` → 0; `err` → 0.
  - RAM strobes are 0 in the reset cycle.
  - A reset during BUSY abandons the access; no load register is updated.

## Timing
- **Minimum latency:** request at cycle 0 in IDLE → BUSY with strobes at cycle 1 → `ramready` at cycle 1 → DONE at cycle 2 (wait = 0, load valid). That is 2 cycles.
- **General latency:** a RAM needing N BUSY cycles gives latency N+1.
- **Back-to-back:** a new grant is possible in IDLE at cycle 3. Peak throughput is one access per 3 cycles.
- **Simultaneous I and D in IDLE:** data is granted; the instruction stalls until a later IDLE.
- **`ramready` outside BUSY:** ignored.
- **`ramready` on the cycle `tcnt == TIMEOUT`:** counts as success; `err` is not set.
- **Load outputs:** change only on the BUSY→DONE edge and hold afterwards.

## Test plan
- **Reset defaults:** assert `rst` 2 cycles → all outputs 0, FSM IDLE; then `iREN=1`, `iaddr=0x40`, RAM ready after 1 cycle returning `0xDEADBEEF` → `iwait` low at cycle 2 with `iload=0xDEADBEEF`.
- **Simultaneous read and fetch:** `dREN` at `0x100` and `iREN` at `0x04` together, RAM 3-cycle latency → data completes first (`dwait` low at cycle 4); instruction is granted at cycle 6 and completes at cycle 9. `ramaddr` is stable during each BUSY window.
- **Write:** `dWEN`, `daddr=0x200`, `dstore=0x12345678` → `ramWEN=1` with latched values until `ramready`; `dload` unchanged; `ramREN=0` throughout.
- **Starvation guard:** data requests held continuously with `iREN` high and `MAX_DSTREAK=4` → grant order D,D,D,D,I,D,…
- **Timeout:** `ramready` held 0 → `err=1` and `dload=0` after 255 BUSY cycles, DONE for 1 cycle. The next request proceeds normally; `err` stays 1 until `rst`.
- **Reset mid-BUSY:** `rst` during a pending read → strobes 0 next cycle, FSM IDLE, loads 0; a late `ramready` is ignored.
